// File: rtl/fp_reduce_sequencer.sv
// fp_reduce_sequencer
// Reduces each set of floating-point beats to a single sum using an external
// adder. Pending operands and returned partial sums share one in-order buffer.
// Whenever two or more entries are present, the two oldest are issued as one
// adder operation. The adder may have any latency, because results are
// appended in arrival order. A set is finished when a single entry remains
// and nothing is still in flight.
module fp_reduce_sequencer #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int DEPTH      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_i,
  input  logic                          valid_i,
  input  logic                          last_i,
  output logic                          ready_o,
  output logic [EXP_WIDTH+FRAC_WIDTH:0] add_a_o,
  output logic [EXP_WIDTH+FRAC_WIDTH:0] add_b_o,
  output logic                          add_valid_o,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0] add_sum_i,
  input  logic                          add_valid_i,
  output logic [EXP_WIDTH+FRAC_WIDTH:0] sum_o,
  output logic                          sum_valid_o,
  output logic                          err_o
);

  localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_buf [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_outstanding;
  logic           r_err;
  logic [W-1:0]   r_add_a;
  logic [W-1:0]   r_add_b;
  logic           r_add_valid;
  logic [W-1:0]   r_sum;
  logic           r_sum_valid;

  logic [CW:0]    w_occ;
  logic           w_ready;
  logic           w_acc;
  logic           w_res_wr;
  logic           w_spurious;
  logic           w_issue;
  logic           w_wr0_en;
  logic           w_wr1_en;
  logic [W-1:0]   w_wr0_data;
  logic [PW-1:0]  w_head1;
  logic [PW-1:0]  w_head2;
  logic [PW-1:0]  w_tail1;
  logic [PW-1:0]  w_tail2;
  logic [PW-1:0]  w_head_nxt;
  logic [PW-1:0]  w_tail_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic [CW-1:0]  w_out_nxt;
  logic           w_drain_done;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every in-flight issue reserves one slot for its returning result.
  // Accepting a beat only while the buffer plus those reserved slots is below
  // DEPTH guarantees that a returning result always finds room.
  assign w_occ      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_ready    = (r_state == COLLECT) && (w_occ < (CW+1)'(DEPTH));
  assign w_acc      = valid_i & w_ready;
  assign w_res_wr   = add_valid_i & (r_outstanding != '0);
  assign w_spurious = add_valid_i & (r_outstanding == '0);
  assign w_issue    = (r_count >= CW'(2));

  assign w_head1 = ptr_inc(r_head);
  assign w_head2 = ptr_inc(w_head1);
  assign w_tail1 = ptr_inc(r_tail);
  assign w_tail2 = ptr_inc(w_tail1);

  // An adder result takes the first write slot, so it is queued ahead of a
  // beat that arrives in the same cycle.
  assign w_wr0_en   = w_res_wr | w_acc;
  assign w_wr1_en   = w_res_wr & w_acc;
  assign w_wr0_data = w_res_wr ? add_sum_i : fp_i;

  assign w_head_nxt  = w_issue ? w_head2 : r_head;
  assign w_tail_nxt  = w_wr1_en ? w_tail2 : (w_wr0_en ? w_tail1 : r_tail);
  assign w_count_nxt = r_count + CW'(w_res_wr) + CW'(w_acc) - (w_issue ? CW'(2) : CW'(0));
  assign w_out_nxt   = r_outstanding + CW'(w_issue) - CW'(w_res_wr);

  assign w_drain_done = (r_state == DRAIN) && (r_count == CW'(1)) &&
                        (r_outstanding == '0) && !add_valid_i && !w_issue;

  // Operand storage: up to two appends per cycle at the tail.
  always_ff @(posedge clk_i) begin
    if (w_wr0_en) r_buf[r_tail]  <= w_wr0_data;
    if (w_wr1_en) r_buf[w_tail1] <= fp_i;
  end

  // Buffer occupancy, in-flight issue count and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_spurious) r_err <= 1'b1;
      if (r_state == DONE) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= w_head_nxt;
        r_tail  <= w_tail_nxt;
        r_count <= w_count_nxt;
      end
    end
  end

  // Adder issue: pop the two oldest entries, older on A and newer on B.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_valid <= 1'b0;
    end else begin
      r_add_valid <= w_issue;
      if (w_issue) begin
        r_add_a <= r_buf[r_head];
        r_add_b <= r_buf[w_head1];
      end
    end
  end

  // Set sequencing; the result is registered on entry to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= COLLECT;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      case (r_state)
        COLLECT: if (w_acc && last_i) r_state <= DRAIN;
        DRAIN: begin
          if (w_drain_done) begin
            r_state     <= DONE;
            r_sum       <= r_buf[r_head];
            r_sum_valid <= 1'b1;
          end
        end
        DONE:    r_state <= COLLECT;
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign ready_o     = w_ready & ~rst_i;
  assign add_a_o     = r_add_a;
  assign add_b_o     = r_add_b;
  assign add_valid_o = r_add_valid;
  assign sum_o       = r_sum;
  assign sum_valid_o = r_sum_valid;
  assign err_o       = r_err;

endmodule

// File: tb/tb_fp_reduce_sequencer.sv
// Testbench for fp_reduce_sequencer. The bench acts as a floating-point adder
// with configurable, in-order latency. It keeps a queue model of the operand
// buffer and compares every DUT output on every falling clock edge.
// Operands are integer-valued floats, so a set's sum is exact and independent
// of the order in which the partial sums are paired.
module tb_fp_reduce_sequencer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_i;
  logic [31:0] fp_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [31:0] add_a_o;
  logic [31:0] add_b_o;
  logic        add_valid_o;
  logic [31:0] add_sum_i;
  logic        add_valid_i;
  logic [31:0] sum_o;
  logic        sum_valid_o;
  logic        err_o;

  fp_reduce_sequencer #(
    .EXP_WIDTH (8),
    .FRAC_WIDTH(23),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .fp_i       (fp_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .ready_o    (ready_o),
    .add_a_o    (add_a_o),
    .add_b_o    (add_b_o),
    .add_valid_o(add_valid_o),
    .add_sum_i  (add_sum_i),
    .add_valid_i(add_valid_i),
    .sum_o      (sum_o),
    .sum_valid_o(sum_valid_o),
    .err_o      (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int due; logic [31:0] val; } res_t;
  typedef struct { logic [31:0] v; logic last; } beat_t;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [31:0] mq[$];
  res_t        adq[$];
  beat_t       stim[$];

  int outst, gsum, set_issues, last_issues, sets_done, drop_seen, both_seen, last_due;
  int lat_min, lat_max, vprob;
  logic [31:0] last_sum;
  logic collecting, pend_collect, err_exp, exp_issue, exp_done, spurious_req;
  logic drv_res, drv_acc, drv_last;
  logic [31:0] drv_res_val, drv_fp;

  // Integer-valued single-precision float to int.
  function automatic int f2i(input logic [31:0] f);
    int e;
    longint m;
    int r;
    e = int'(f[30:23]);
    if (e < 127 || e > 157) return 0;
    m = longint'({40'd0, 1'b1, f[22:0]});
    if (e >= 150) m = m << (e - 150);
    else m = m >> (150 - e);
    r = int'(m);
    return f[31] ? -r : r;
  endfunction

  // Exact int (|v| < 2^24) to single-precision float.
  function automatic logic [31:0] i2f(input int v);
    logic [31:0] a;
    logic [31:0] sh;
    int p;
    if (v == 0) return 32'h0;
    a = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 31; i++) if (a[i]) p = i;
    sh = (p <= 23) ? (a << (23 - p)) : (a >> (p - 23));
    return {(v < 0), 8'(127 + p), sh[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    mq.delete(); adq.delete(); stim.delete();
    outst = 0; gsum = 0; set_issues = 0; last_due = -1000;
    collecting = 1'b1; pend_collect = 1'b0; err_exp = 1'b0;
    exp_issue = 1'b0; exp_done = 1'b0; spurious_req = 1'b0;
    drv_res = 1'b0; drv_acc = 1'b0; drv_last = 1'b0;
    drv_res_val = 32'h0; drv_fp = 32'h0;
    valid_i = 1'b0; last_i = 1'b0; fp_i = 32'h0;
    add_valid_i = 1'b0; add_sum_i = 32'h0;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_ready_o"}, ready_o, 1'b0);
    chk1({tag, "_add_valid_o"}, add_valid_o, 1'b0);
    chk1({tag, "_sum_valid_o"}, sum_valid_o, 1'b0);
    chk1({tag, "_err_o"}, err_o, 1'b0);
    chk({tag, "_add_a_o"}, add_a_o, 32'h0);
    chk({tag, "_add_b_o"}, add_b_o, 32'h0);
    chk({tag, "_sum_o"}, sum_o, 32'h0);
  endtask

  task automatic add_beat(input logic [31:0] v, input logic last);
    beat_t b;
    b.v = v;
    b.last = last;
    stim.push_back(b);
  endtask

  // One clock cycle: apply the effects of the edge just passed to the model,
  // compare every output, then drive the inputs for the next edge.
  task automatic step();
    logic [31:0] ea, eb;
    logic exp_rdy;
    int d;
    res_t r;
    beat_t b;
    @(negedge clk);
    cyc++;
    if (pend_collect) begin collecting = 1'b1; pend_collect = 1'b0; end
    if (drv_res) begin
      if (outst > 0) begin mq.push_back(drv_res_val); outst--; end
      else err_exp = 1'b1;
    end
    if (drv_acc) begin
      mq.push_back(drv_fp);
      gsum += f2i(drv_fp);
      if (drv_res) both_seen++;
      if (drv_last) collecting = 1'b0;
    end
    chk1("add_valid_o", add_valid_o, exp_issue);
    if (add_valid_o) begin
      ea = 32'h0; eb = 32'h0;
      if (mq.size() >= 2) begin ea = mq.pop_front(); eb = mq.pop_front(); end
      chk("add_a_o", add_a_o, ea);
      chk("add_b_o", add_b_o, eb);
      outst++;
      set_issues++;
      d = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      r.due = d;
      r.val = i2f(f2i(ea) + f2i(eb));
      adq.push_back(r);
    end
    chk1("sum_valid_o", sum_valid_o, exp_done);
    if (sum_valid_o) begin
      chk("sum_vs_buffer", sum_o, (mq.size() == 1) ? mq[0] : 32'hDEADBEEF);
      chk("sum_vs_golden", sum_o, i2f(gsum));
      last_sum = sum_o;
      last_issues = set_issues;
      sets_done++;
      mq.delete(); gsum = 0; set_issues = 0;
      pend_collect = 1'b1;
    end
    chk1("err_o", err_o, err_exp);
    exp_rdy = collecting && ((mq.size() + outst) < DEPTH);
    chk1("ready_o", ready_o, exp_rdy);
    if (!ready_o && collecting && ((mq.size() + outst) == DEPTH)) drop_seen++;

    drv_res = 1'b0;
    drv_res_val = $urandom;
    if (adq.size() > 0 && adq[0].due <= cyc) begin
      r = adq.pop_front();
      drv_res = 1'b1;
      drv_res_val = r.val;
    end else if (spurious_req) begin
      drv_res = 1'b1;
      spurious_req = 1'b0;
    end
    add_valid_i = drv_res;
    add_sum_i = drv_res_val;
    drv_acc = 1'b0;
    if (stim.size() > 0 && int'($urandom_range(99, 0)) < vprob) begin
      valid_i = 1'b1;
      fp_i = stim[0].v;
      last_i = stim[0].last;
      if (ready_o) begin
        b = stim.pop_front();
        drv_acc = 1'b1;
        drv_fp = b.v;
        drv_last = b.last;
      end
    end else begin
      valid_i = 1'b0;
      fp_i = $urandom;
      last_i = 1'($urandom);
    end
    exp_issue = (mq.size() >= 2);
    exp_done = !collecting && !pend_collect && (mq.size() == 1) && (outst == 0) && !drv_res;
  endtask

  task automatic wait_set();
    int target;
    int guard;
    target = sets_done + 1;
    guard = 0;
    while (sets_done < target && guard < 3000) begin
      step();
      guard++;
    end
    if (sets_done < target) begin
      nchk++;
      nerr++;
      $display("FAIL set_timeout: got no sum_valid_o within %0d cycles", guard);
    end
  endtask

  initial begin
    int n;
    int g;
    sets_done = 0; drop_seen = 0; both_seen = 0; last_issues = 0; last_sum = 32'h0;
    lat_min = 1; lat_max = 1; vprob = 100;
    rst_i = 1'b1;
    reset_model();
    #3;
    check_zero("por");

    chk("pin_i2f_10", i2f(10), 32'h41200000);
    chk("pin_i2f_16", i2f(16), 32'h41800000);
    chk("pin_i2f_4", i2f(4), 32'h40800000);
    chk("pin_f2i_2", 32'(f2i(32'h40000000)), 32'd2);
    chk("pin_i2f_neg3", i2f(-3), 32'hC0400000);

    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk1("ready_after_release", ready_o, 1'b1);

    // Spurious adder result with nothing outstanding.
    spurious_req = 1'b1;
    repeat (4) step();
    chk1("err_sticky", err_o, 1'b1);

    // 1+2+3+4 with a 4-cycle adder.
    lat_min = 4; lat_max = 4; vprob = 100;
    add_beat(32'h3F800000, 1'b0);
    add_beat(32'h40000000, 1'b0);
    add_beat(32'h40400000, 1'b0);
    add_beat(32'h40800000, 1'b1);
    wait_set();
    chk("sum_1234", last_sum, 32'h41200000);
    chk("issues_1234", 32'(last_issues), 32'd3);

    // Single-beat set.
    add_beat(32'h40400000, 1'b1);
    wait_set();
    chk("sum_single", last_sum, 32'h40400000);
    chk("issues_single", 32'(last_issues), 32'd0);

    // Sixteen beats of 1.0 back-to-back against a 12-cycle adder.
    lat_min = 12; lat_max = 12; drop_seen = 0;
    for (int k = 0; k < 16; k++) add_beat(32'h3F800000, k == 15);
    wait_set();
    chk("sum_16", last_sum, 32'h41800000);
    chk("issues_16", 32'(last_issues), 32'd15);
    chk1("ready_drop_at_full", drop_seen > 0, 1'b1);

    // Random sets, random adder latency, random input gaps.
    for (int s = 0; s < 30; s++) begin
      lat_min = int'($urandom_range(3, 1));
      lat_max = lat_min + int'($urandom_range(8, 0));
      vprob = int'($urandom_range(100, 30));
      n = int'($urandom_range(12, 1));
      for (int k = 0; k < n; k++) add_beat(i2f(int'($urandom_range(2000, 0)) - 1000), k == n - 1);
      wait_set();
      chk("rand_issue_count", 32'(last_issues), 32'(n - 1));
    end
    chk1("same_cycle_result_and_beat", both_seen > 0, 1'b1);

    // Reset while draining a set.
    lat_min = 10; lat_max = 10; vprob = 100;
    for (int k = 0; k < 8; k++) add_beat(i2f(k + 1), k == 7);
    g = 0;
    while (!(!collecting && outst > 0) && g < 500) begin
      step();
      g++;
    end
    chk1("reached_drain", !collecting && outst > 0, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check_zero("mid_drain_reset");
    reset_model();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk1("ready_after_drain_reset", ready_o, 1'b1);
    lat_min = 2; lat_max = 5;
    add_beat(32'h40000000, 1'b0);
    add_beat(32'h40000000, 1'b1);
    wait_set();
    chk("sum_after_reset", last_sum, 32'h40800000);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fp_reduce_sequencer.md
FP_REDUCE_SEQUENCER -- requirements
Module: fp_reduce_sequencer

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 23, fraction field width; W = 1+EXP_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 8, operand buffer entries; legal range 2..64.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk_i  input  1  clock, all state on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 fp_i  input  W  input operand beat.
REQ-008 valid_i  input  1  fp_i valid.
REQ-009 last_i  input  1  marks final beat of a set, qualified by valid_i.
REQ-010 ready_o  output  1  beat accepted when valid_i && ready_o.
REQ-011 add_a_o  output  W  adder operand A, registered.
REQ-012 add_b_o  output  W  adder operand B, registered.
REQ-013 add_valid_o  output  1  adder issue strobe, registered.
REQ-014 add_sum_i  input  W  adder result.
REQ-015 add_valid_i  input  1  adder result valid; the adder has no backpressure.
REQ-016 sum_o  output  W  reduced sum of the set, registered.
REQ-017 sum_valid_o  output  1  one-cycle strobe qualifying sum_o.
REQ-018 err_o  output  1  sticky: add_valid_i seen with zero outstanding issues.

Function
REQ-019 SHALL hold pending operands in an in-order buffer of DEPTH entries accepting up to 2 writes and 2 reads per cycle.
REQ-020 SHALL track outstanding = issues minus returned results; width clog2(DEPTH+1).
REQ-021 SHALL drive ready_o = (state==COLLECT) && (count + outstanding < DEPTH), from registered state only.
REQ-022 SHALL write add_sum_i into the buffer every cycle add_valid_i=1 with outstanding>0; results are never dropped.
REQ-023 SHALL, on a same-cycle adder result and accepted input, write the adder result first, then fp_i.
REQ-024 SHALL, when registered count>=2, pop the two oldest entries and next cycle present add_a_o=older, add_b_o=newer, add_valid_o=1; at most one issue per cycle.
REQ-025 SHALL deassert add_valid_o in any cycle without an issue; add_a_o/add_b_o hold last value.
REQ-026 States: COLLECT (accept beats), DRAIN (no accept), DONE (emit result).
REQ-027 COLLECT->DRAIN on an accepted beat with last_i=1.
REQ-028 DRAIN->DONE when count==1, outstanding==0, add_valid_i==0, no issue pending in that cycle.
REQ-029 DONE: sum_o=remaining entry, sum_valid_o=1 for exactly one cycle, buffer cleared, ->COLLECT next cycle.
REQ-030 A set of one beat SHALL produce sum_o equal to that beat with zero adder issues.
REQ-031 Issues SHALL proceed in COLLECT as well as DRAIN (reduction overlaps input).
REQ-032 add_valid_i with outstanding==0 SHALL be ignored and set err_o until reset.
REQ-033 Block SHALL be latency-agnostic: any fixed or variable adder latency >=1 cycle yields the same sum_o for the same beat/result order.

Reset
REQ-034 On rst_i asserted, immediately: state=COLLECT, count=0, outstanding=0, ready_o=0 while asserted, add_valid_o=0, sum_valid_o=0, err_o=0, add_a_o=add_b_o=sum_o=0.
REQ-035 Reset mid-set SHALL discard the partial set; first cycle after release ready_o=1.

Verification
REQ-036 Set {1.0 0x3F800000, 2.0 0x40000000, 3.0 0x40400000, 4.0 0x40800000(last)}, 4-cycle adder model -> single sum_valid_o, sum_o=0x41200000 (10.0), exactly 3 adder issues.
REQ-037 Single beat 0x40400000 with last_i=1 -> sum_o=0x40400000, add_valid_o never asserted.
REQ-038 DEPTH=4, 16 beats of 1.0 back-to-back, adder latency 12 -> ready_o drops when count+outstanding=4, no result lost, sum_o=0x41800000 (16.0).
REQ-039 Adder result and input beat in the same cycle -> both stored, result ahead of beat; sum matches golden model using same pairing order.
REQ-040 Spurious add_valid_i after reset with no issue -> err_o=1 and stays 1; buffer count unchanged.
REQ-041 Reset asserted mid-DRAIN -> all outputs 0 at once; next set {2.0,2.0(last)} -> sum_o=0x40800000.
